// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl - request sequencer in front of a synchronous single-port memory.
//
// Accepts single-beat write/read commands over a valid/ready handshake,
// drives the memory read/write strobes, address and write data, captures
// the registered memory read data and returns it over a valid/ready
// response channel. read and write are never asserted in the same cycle.
//
// Optional feature macro: MEM_SEQ_CTRL_BURST_EN
//   defined   -> req_len is honoured, reads return req_len+1 beats with
//                wrapping addresses
//   undefined -> every read returns exactly one beat
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   req_valid/req_ready      command handshake
//   req_write                1 = write, 0 = read
//   req_addr, req_wdata      start address, write data
//   req_len                  burst length minus 1 (burst builds only)
//   rsp_valid/rsp_ready      read response handshake
//   rsp_rdata                read data
//   mem_read, mem_write      memory strobes (registered, mutually exclusive)
//   mem_addr, mem_wdata      memory address / write data (hold when idle)
//   mem_rdata                registered memory read data
module mem_seq_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    RWAIT = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t state_r;
  state_t state_s;

  logic              req_ready_s;
  logic              rsp_valid_s;
  logic [DATA_W-1:0] rsp_rdata_s;
  logic              mem_read_s;
  logic              mem_write_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;

`ifdef MEM_SEQ_CTRL_BURST_EN
  // Beats still to be issued after the one currently in flight.
  logic [2:0] beats_r;
  logic [2:0] beats_s;
`else
  // req_len has no effect in single-beat builds.
  logic unused_len_s;
  assign unused_len_s = ^req_len;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_s     = state_r;
    req_ready_s = req_ready;
    rsp_valid_s = rsp_valid;
    rsp_rdata_s = rsp_rdata;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    mem_addr_s  = mem_addr;
    mem_wdata_s = mem_wdata;
`ifdef MEM_SEQ_CTRL_BURST_EN
    beats_s     = beats_r;
`endif
    case (state_r)
      IDLE: begin
        if (req_valid && req_ready) begin
          req_ready_s = 1'b0;
          mem_addr_s  = req_addr;
          if (req_write) begin
            state_s     = WR;
            mem_write_s = 1'b1;
            mem_wdata_s = req_wdata;
          end else begin
            state_s    = RD;
            mem_read_s = 1'b1;
`ifdef MEM_SEQ_CTRL_BURST_EN
            beats_s    = req_len;
`endif
          end
        end else begin
          // Also raises req_ready on the first edge after reset release.
          req_ready_s = 1'b1;
        end
      end
      WR: begin
        state_s     = IDLE;
        req_ready_s = 1'b1;
      end
      RD: begin
        state_s = RWAIT;
      end
      RWAIT: begin
        // Memory registered the read on the previous edge; capture it now.
        state_s     = RESP;
        rsp_rdata_s = mem_rdata;
        rsp_valid_s = 1'b1;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_s = 1'b0;
`ifdef MEM_SEQ_CTRL_BURST_EN
          if (beats_r != 3'd0) begin
            state_s    = RD;
            beats_s    = beats_r - 3'd1;
            mem_read_s = 1'b1;
            mem_addr_s = mem_addr + ADDR_W'(1);
          end else begin
            state_s     = IDLE;
            req_ready_s = 1'b1;
          end
`else
          state_s     = IDLE;
          req_ready_s = 1'b1;
`endif
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s     = IDLE;
        req_ready_s = 1'b0;
        rsp_valid_s = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= {DATA_W{1'b0}};
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
    end else begin
      req_ready <= req_ready_s;
      rsp_valid <= rsp_valid_s;
      rsp_rdata <= rsp_rdata_s;
      mem_read  <= mem_read_s;
      mem_write <= mem_write_s;
      mem_addr  <= mem_addr_s;
      mem_wdata <= mem_wdata_s;
    end
  end

`ifdef MEM_SEQ_CTRL_BURST_EN
  // Remaining-beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beats_r <= 3'd0;
    end else begin
      beats_r <= beats_s;
    end
  end
`endif

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Self-checking bench for mem_seq_ctrl with a behavioural 32x8 synchronous
// memory attached. Directed vectors, hand-computed expected values.
module tb_mem_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [4:0] req_addr = 5'd0;
  logic [7:0] req_wdata = 8'd0;
  logic [2:0] req_len = 3'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_rdata;
  logic       mem_read;
  logic       mem_write;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'd0;

  logic [7:0] mem_model [0:31];
  int n_checks = 0;
  int n_fail = 0;
  int overlap_cnt = 0;

  mem_seq_ctrl #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous memory: write lands at the edge, read data registered.
  initial begin
    for (int i = 0; i < 32; i++) mem_model[i] = 8'd0;
  end
  always @(posedge clk) begin
    if (mem_write) mem_model[mem_addr] <= mem_wdata;
    if (mem_read) mem_rdata <= mem_model[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_read && mem_write) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for req_ready, present a command, return 1 time unit after the accept edge.
  task automatic send(input logic wr, input logic [4:0] a, input logic [7:0] d, input logic [2:0] len);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      check("send_timeout", 32'd0, 32'd1);
    end else begin
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_len = len;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
    end
  endtask

  // Wait for a response beat, check it, complete the handshake.
  task automatic recv(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (rsp_valid !== 1'b1) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check(tag, {24'd0, rsp_rdata}, {24'd0, exp});
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
    end
  endtask

  initial begin
    int seen;
    int first_acc;
    int last_acc;
    int cyc;
    int idx;
    logic acc;

    // Reset state
    #2;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_mem_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    check("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_ready_low", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("rel_ready_high", {31'd0, req_ready}, 32'd1);

    // Write 5 <- A5 with cycle timing
    send(1'b1, 5'd5, 8'hA5, 3'd0);
    check("wr_strobe", {30'd0, mem_write, mem_read}, 32'd2);
    check("wr_addr", {27'd0, mem_addr}, 32'd5);
    check("wr_data", {24'd0, mem_wdata}, 32'hA5);
    check("wr_ready_low", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    check("wr_done_strobe", {31'd0, mem_write}, 32'd0);
    check("wr_done_ready", {31'd0, req_ready}, 32'd1);
    check("wr_addr_hold", {27'd0, mem_addr}, 32'd5);
    check("wr_mem", {24'd0, mem_model[5]}, 32'hA5);

    // Read 5: latency 2
    send(1'b0, 5'd5, 8'h00, 3'd0);
    check("rd_strobe", {30'd0, mem_read, mem_write}, 32'd2);
    check("rd_addr", {27'd0, mem_addr}, 32'd5);
    @(posedge clk); #1;
    check("rd_t1_strobe", {31'd0, mem_read}, 32'd0);
    check("rd_t1_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    check("rd_t2_valid", {31'd0, rsp_valid}, 32'd1);
    recv("rd5_data", 8'hA5);
    check("rd_post_valid", {31'd0, rsp_valid}, 32'd0);
    check("rd_post_ready", {31'd0, req_ready}, 32'd1);

    // Backpressure on read of addr 3
    send(1'b1, 5'd3, 8'h3C, 3'd0);
    send(1'b0, 5'd3, 8'h00, 3'd0);
    @(posedge clk); @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_data", {24'd0, rsp_rdata}, 32'h3C);
      check("bp_ready_low", {31'd0, req_ready}, 32'd0);
    end
    recv("bp_final", 8'h3C);

    // Burst / single beat across the wrap point
    send(1'b1, 5'd30, 8'h11, 3'd0);
    send(1'b1, 5'd31, 8'h22, 3'd0);
    send(1'b1, 5'd0, 8'h33, 3'd0);
    send(1'b1, 5'd1, 8'h44, 3'd0);
    send(1'b0, 5'd30, 8'h00, 3'd3);
`ifdef MEM_SEQ_CTRL_BURST_EN
    recv("burst_b0", 8'h11);
    recv("burst_b1", 8'h22);
    recv("burst_b2", 8'h33);
    recv("burst_b3", 8'h44);
`else
    recv("single_b0", 8'h11);
`endif
    check("after_rd_ready", {31'd0, req_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("no_extra_beat", seen, 32'd0);

    // Reset mid-read (RWAIT)
    send(1'b0, 5'd5, 8'h00, 3'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    check("mid_rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check("mid_rst_addr", {27'd0, mem_addr}, 32'd0);
    check("mid_rst_rdata", {24'd0, rsp_rdata}, 32'd0);
    check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rel_ready_low", {31'd0, req_ready}, 32'd0);
    seen = 0;
    @(negedge clk);
    check("mid_rel_ready_high", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    check("mid_rel_no_rsp", seen, 32'd0);

    // Back-to-back writes with req_valid held high
    idx = 0; cyc = 0; first_acc = -1; last_acc = -1;
    req_write = 1'b1; req_len = 3'd0; req_addr = 5'd0; req_wdata = 8'd0;
    req_valid = 1'b1;
    while (idx < 32 && cyc < 200) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      cyc++;
      if (acc) begin
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        idx++;
        #1;
        req_addr = idx[4:0];
        req_wdata = idx[7:0];
      end
    end
    req_valid = 1'b0;
    check("b2b_count", idx, 32'd32);
    check("b2b_span", last_acc - first_acc, 32'd62);
    for (int i = 0; i < 32; i++) begin
      logic [7:0] e;
      e = i[7:0];
      send(1'b0, i[4:0], 8'h00, 3'd0);
      recv("b2b_readback", e);
    end

    check("rw_overlap", overlap_cnt, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_seq_ctrl.md
# mem_seq_ctrl

Request sequencer sitting directly upstream of the 32×8 synchronous memory model. It accepts single-beat write and read commands over a valid/ready handshake and drives the memory's `read`/`write`/`addr`/`data_in` pins. It captures the registered `data_out` and returns read data over a valid/ready response channel, optionally as multi-beat read bursts. It guarantees `read` and `write` are never asserted together, so the memory never sees an ignored cycle.

## Interface
- `ADDR_W`, default 5: address width; memory depth is 2**ADDR_W.
- `DATA_W`, default 8: data width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: command valid.
- `req_ready` out 1: command accepted when `req_valid && req_ready` at a rising edge.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: start address.
- `req_wdata` in DATA_W: write data.
- `req_len` in 3: read burst length minus 1 (1–8 beats); ignored unless the burst feature is compiled in.
- `rsp_valid` out 1: read data valid.
- `rsp_ready` in 1: consumer accepts `rsp_rdata`.
- `rsp_rdata` out DATA_W: read data.
- `mem_read` out 1: to memory `read`.
- `mem_write` out 1: to memory `write`.
- `mem_addr` out ADDR_W: to memory `addr`.
- `mem_wdata` out DATA_W: to memory `data_in`.
- `mem_rdata` in DATA_W: from memory `data_out`.

## Operation
- FSM states: IDLE, WR, RD, RWAIT, RESP.
- All outputs are registered.
- **IDLE:** `req_ready`=1. On accept:
  - write → WR, latching addr/wdata.
  - read → RD, latching addr, beats = `req_len`+1 (burst) or 1.
- **WR:** `mem_write`=1 and `mem_read`=0 for exactly one cycle; `req_ready`=0; returns to IDLE. Writes produce no response.
- **RD:** `mem_read`=1 and `mem_write`=0 for one cycle → RWAIT.
- **RWAIT:** strobes low; the memory registers data on this edge. The next edge captures `mem_rdata` into `rsp_rdata`, sets `rsp_valid` → RESP.
- **RESP:** holds `rsp_valid` and `rsp_rdata` stable until `rsp_ready`. On handshake:
  - beats remaining → RD with addr+1;
  - otherwise → IDLE.
- Address increment is modulo 2**ADDR_W: 31 wraps to 0.
- `mem_addr` and `mem_wdata` hold their last value when strobes are low.
- **Reset (asserted at any time, including mid-burst):** state=IDLE; `req_ready`, `rsp_valid`, `mem_read`, `mem_write` = 0; `mem_addr`, `mem_wdata`, `rsp_rdata` = 0. Any in-flight burst is abandoned with no partial response.
- `req_ready` rises on the first rising edge after `rst` deasserts.

## Timing
- Accept at edge T.
- **Write:** `mem_write` high during cycle T..T+1; memory updated at edge T+1. `req_ready` high again after edge T+1, giving a 2-cycle write throughput.
- **Read:** `mem_read` high during T..T+1; memory `data_out` valid after T+1; `rsp_valid` high after edge T+2, a latency of 2.
- **Burst beat:** next `mem_read` begins on the edge where `rsp_ready` is seen. With `rsp_ready` tied high, there is one beat per 3 cycles.
- **Read immediately after write to the same address:** returns the new data, because the write lands at T+1 and the read strobe is issued at T+2 or later.
- `req_*` inputs are sampled only at the accept edge; changes at other times are ignored.

## Configuration
- `MEM_SEQ_CTRL_BURST_EN`
  - Defined: `req_len` is honoured; reads return `req_len`+1 consecutive beats with wrapping addresses.
  - Undefined: `req_len` is ignored; every read returns exactly one beat, and the beat counter logic is absent.

## Test plan
- Reset mid-operation: assert `rst` during RWAIT → all outputs 0 immediately (asynchronous). After release, `req_ready`=1 one edge later and no `rsp_valid` pulse appears.
- Write then read: write addr 5 data 0xA5, then read addr 5 → `rsp_rdata`=0xA5 two cycles after read accept. `mem_read` and `mem_write` never high together.
- Backpressure: read addr 3 (holding 0x3C) with `rsp_ready`=0 for 4 cycles → `rsp_valid`=1 and `rsp_rdata`=0x3C stable throughout; `req_ready`=0 until the handshake completes.
- Burst wrap (BURST_EN): preload addr 30/31/0/1 with 0x11/0x22/0x33/0x44, then read addr 30 with `req_len`=3 → beats 0x11, 0x22, 0x33, 0x44 in order.
- No burst (macro undefined): read addr 30 with `req_len`=3 → a single beat 0x11, then `req_ready`=1.
- Back-to-back writes: writes to addrs 0–31 with data = addr, `req_valid` held high → one accept every 2 cycles. A readback of all 32 addresses matches.
